// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready handshake and
// saturating corrected/uncorrectable error counters.
module hamming_secded_pipe #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W+P+1, valid for DATA_W up to 64
    localparam int unsigned P  = (DATA_W <= 4)  ? 3 :
                                 (DATA_W <= 11) ? 4 :
                                 (DATA_W <= 26) ? 5 :
                                 (DATA_W <= 57) ? 6 : 7,
    localparam int unsigned CW = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err_corr,
    output logic              out_err_uncorr,
    output logic [P-1:0]      out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    // Positions 1..CW-1 whose index has bit b set; syndrome bit b is their parity.
    function automatic logic [CW-1:0] syn_mask(input int unsigned b);
        logic [CW-1:0] m;
        m = '0;
        for (int unsigned i = 1; i < CW; i++) begin
            if (((i >> b) & 1) != 0) m = m | (CW'(1) << i);
        end
        return m;
    endfunction

    // Codeword position of data bit j: the j-th non-power-of-two position.
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned n;
        int unsigned pos;
        n   = 0;
        pos = 0;
        for (int unsigned i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == j) pos = i;
                n++;
            end
        end
        return pos;
    endfunction

    logic              s1_valid;
    logic [CW-1:0]     s1_code;
    logic [P-1:0]      s1_syn;
    logic              s1_par;

    logic              s1_en;
    logic              s2_en;
    logic [P-1:0]      syn_c;
    logic              par_c;
    logic              in_range;
    logic              err_corr_c;
    logic              err_uncorr_c;
    logic [CW-1:0]     flip_mask;
    logic [CW-1:0]     fixed_code;
    logic [DATA_W-1:0] data_c;
    logic              xfer;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en && !rst;
    assign xfer     = out_valid && out_ready;

    for (genvar b = 0; b < P; b++) begin : g_syn
        localparam logic [CW-1:0] Mask = syn_mask(b);
        assign syn_c[b] = ^(in_code & Mask);
    end
    assign par_c = ^in_code;

    always_comb begin
        in_range     = 32'(s1_syn) < CW;
        err_corr_c   = s1_par && in_range;
        err_uncorr_c = (s1_syn != '0 && !s1_par) || (s1_par && !in_range);
        flip_mask    = (err_corr_c && s1_syn != '0) ? (CW'(1) << s1_syn) : '0;
        fixed_code   = s1_code ^ flip_mask;
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_extract
        localparam int unsigned Pos = data_pos(j);
        assign data_c[j] = fixed_code[Pos];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_code        <= '0;
            s1_syn         <= '0;
            s1_par         <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_err_corr   <= 1'b0;
            out_err_uncorr <= 1'b0;
            out_syndrome   <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_code <= in_code;
                    s1_syn  <= syn_c;
                    s1_par  <= par_c;
                end
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data       <= data_c;
                    out_err_corr   <= err_corr_c;
                    out_err_uncorr <= err_uncorr_c;
                    out_syndrome   <= s1_syn;
                end
            end
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (xfer) begin
            if (out_err_corr && cnt_corr != '1) cnt_corr <= cnt_corr + CNT_W'(1);
            if (out_err_uncorr && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed bench for hamming_secded_pipe with DATA_W=4, CNT_W=2 (8-bit codewords).
module tb_hamming_secded_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_err_corr;
    logic       out_err_uncorr;
    logic [2:0] out_syndrome;
    logic       cnt_clr;
    logic [1:0] cnt_corr;
    logic [1:0] cnt_uncorr;

    int n_vec = 0;
    int n_bad = 0;

    hamming_secded_pipe #(
        .DATA_W(4),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err_corr  (out_err_corr),
        .out_err_uncorr(out_err_uncorr),
        .out_syndrome  (out_syndrome),
        .cnt_clr       (cnt_clr),
        .cnt_corr      (cnt_corr),
        .cnt_uncorr    (cnt_uncorr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] code);
        in_valid = 1'b1;
        in_code  = code;
        step();
        in_valid = 1'b0;
    endtask

    // Hamming(7,4) parity equations plus overall even parity in bit 0.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c[3] = d[0];
        c[5] = d[1];
        c[6] = d[2];
        c[7] = d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        c[0] = ^c[7:1];
        return c;
    endfunction

    task automatic test_reset;
        step();
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if ({out_err_corr, out_err_uncorr} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", out_err_corr, out_err_uncorr); end
        n_vec++; if (out_syndrome !== 3'd0) begin n_bad++; $display("FAIL reset_syndrome: got %0d want 0", out_syndrome); end
        n_vec++; if ({cnt_corr, cnt_uncorr} !== 4'h0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_corr, cnt_uncorr); end
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_clean;
        push(8'h5A);
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clean_latency: got out_valid %b want 0 after 1 cycle", out_valid); end
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clean_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 4'b0101) begin n_bad++; $display("FAIL clean_data: got %b want 0101", out_data); end
        n_vec++; if ({out_err_corr, out_err_uncorr} !== 2'b00) begin n_bad++; $display("FAIL clean_flags: got %b%b want 00", out_err_corr, out_err_uncorr); end
        n_vec++; if (out_syndrome !== 3'd0) begin n_bad++; $display("FAIL clean_syndrome: got %0d want 0", out_syndrome); end
        step();
    endtask

    task automatic test_single;
        push(8'h7A);
        step();
        n_vec++; if (out_data !== 4'b0101) begin n_bad++; $display("FAIL single_data: got %b want 0101", out_data); end
        n_vec++; if ({out_err_corr, out_err_uncorr} !== 2'b10) begin n_bad++; $display("FAIL single_flags: got %b%b want 10", out_err_corr, out_err_uncorr); end
        n_vec++; if (out_syndrome !== 3'd5) begin n_bad++; $display("FAIL single_syndrome: got %0d want 5", out_syndrome); end
        step();
        n_vec++; if (cnt_corr !== 2'd1) begin n_bad++; $display("FAIL single_cnt_corr: got %0d want 1", cnt_corr); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_no_dup: got out_valid %b want 0", out_valid); end
        push(8'h5B);
        step();
        n_vec++; if (out_data !== 4'b0101) begin n_bad++; $display("FAIL bit0_data: got %b want 0101", out_data); end
        n_vec++; if ({out_err_corr, out_err_uncorr} !== 2'b10) begin n_bad++; $display("FAIL bit0_flags: got %b%b want 10", out_err_corr, out_err_uncorr); end
        n_vec++; if (out_syndrome !== 3'd0) begin n_bad++; $display("FAIL bit0_syndrome: got %0d want 0", out_syndrome); end
        step();
        n_vec++; if (cnt_corr !== 2'd2) begin n_bad++; $display("FAIL bit0_cnt_corr: got %0d want 2", cnt_corr); end
    endtask

    task automatic test_double;
        push(8'h3A);
        step();
        n_vec++; if (out_data !== 4'b0011) begin n_bad++; $display("FAIL double_raw_data: got %b want 0011", out_data); end
        n_vec++; if ({out_err_corr, out_err_uncorr} !== 2'b01) begin n_bad++; $display("FAIL double_flags: got %b%b want 01", out_err_corr, out_err_uncorr); end
        n_vec++; if (out_syndrome !== 3'd3) begin n_bad++; $display("FAIL double_syndrome: got %0d want 3", out_syndrome); end
        step();
        n_vec++; if (cnt_uncorr !== 2'd1) begin n_bad++; $display("FAIL double_cnt_uncorr: got %0d want 1", cnt_uncorr); end
        n_vec++; if (cnt_corr !== 2'd2) begin n_bad++; $display("FAIL double_cnt_corr: got %0d want 2", cnt_corr); end
    endtask

    task automatic test_counters;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_vec++; if ({cnt_corr, cnt_uncorr} !== 4'h0) begin n_bad++; $display("FAIL clr_counters: got %0d/%0d want 0/0", cnt_corr, cnt_uncorr); end
        in_valid = 1'b1;
        in_code  = 8'h7A;
        repeat (5) step();
        in_valid = 1'b0;
        repeat (3) step();
        n_vec++; if (cnt_corr !== 2'd3) begin n_bad++; $display("FAIL saturate_cnt_corr: got %0d want 3", cnt_corr); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL saturate_drained: got out_valid %b want 0", out_valid); end
        push(8'h7A);
        step();
        n_vec++; if (out_err_corr !== 1'b1) begin n_bad++; $display("FAIL clr_race_corr: got %b want 1", out_err_corr); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_vec++; if (cnt_corr !== 2'd0) begin n_bad++; $display("FAIL clr_priority: got %0d want 0", cnt_corr); end
        push(8'h7A);
        step();
        step();
        n_vec++; if (cnt_corr !== 2'd1) begin n_bad++; $display("FAIL count_after_clr: got %0d want 1", cnt_corr); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  exp_d [8] = '{4'd3, 4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6};
        logic [31:0] pat = 32'hB2C5_39A6;
        int          sent = 0;
        int          recv = 0;
        logic        stall_prev = 1'b0;
        logic [3:0]  data_prev = 4'h0;
        logic        exp_rdy;
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_code   = encode(exp_d[(sent < 8) ? sent : 0]);
            out_ready = pat[cyc % 32];
            #1;
            exp_rdy = !((sent - recv) == 2 && !out_ready);
            n_vec++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy); end
            if (stall_prev) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== data_prev) begin n_bad++; $display("FAIL bp_stall_hold cyc %0d: got %b/%h want 1/%h", cyc, out_valid, out_data, data_prev); end
            end
            if (out_valid && out_ready) begin
                n_vec++; if (out_data !== exp_d[recv] || out_err_corr || out_err_uncorr) begin n_bad++; $display("FAIL bp_order word %0d: got %h flags %b%b want %h flags 00", recv, out_data, out_err_corr, out_err_uncorr, exp_d[recv]); end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            step();
        end
        in_valid = 1'b0;
        n_vec++; if (recv != 8) begin n_bad++; $display("FAIL bp_delivered: got %0d words want 8", recv); end
        out_ready = 1'b1;
        repeat (3) step();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_extra: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h7A;
        step();
        in_code = 8'h3A;
        step();
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if ({cnt_corr, cnt_uncorr} !== 4'h0) begin n_bad++; $display("FAIL mid_rst_counters: got %0d/%0d want 0/0", cnt_corr, cnt_uncorr); end
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_held_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale_out cyc %0d: got %b want 0", i, out_valid); end
        end
        push(8'h5A);
        step();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 4'b0101) begin n_bad++; $display("FAIL mid_restart: got %b/%b want 1/0101", out_valid, out_data); end
        n_vec++; if ({out_err_corr, out_err_uncorr} !== 2'b00 || cnt_corr !== 2'd0) begin n_bad++; $display("FAIL mid_restart_flags: got %b%b cnt %0d want 00 cnt 0", out_err_corr, out_err_uncorr, cnt_corr); end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 8'h00;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_counters();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
